// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clkdiv_bank divider slice.
// Holds the minimum legal divisor and the per-channel run-state encoding.
package clkdiv_pkg;

   localparam int DIV_MIN = 2;

   typedef enum logic [1:0] {
      STOPPED  = 2'd0,
      RUNNING  = 2'd1,
      STOPPING = 2'd2
   } chanState_t;

endpackage

// File: rtl/clkdiv_chan.sv
// One glitch-free clock divider channel: active divisor, one-deep pending divisor,
// phase counter and registered clkOut/tick generated from the next-state values.
module clkdiv_chan
   import clkdiv_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clkIn,
   input  logic             rstN,
   input  logic             en,
   input  logic             syncReq,
   input  logic             ldValid,
   input  logic [WIDTH-1:0] ldData,
   output logic             pendFull,
   output logic             clkOut,
   output logic             tick
);

   localparam logic [WIDTH-1:0] RST_DIV =
      (DEFAULT_DIV < DIV_MIN) ? WIDTH'(DIV_MIN) : WIDTH'(DEFAULT_DIV);

   function automatic logic [WIDTH-1:0] clampDiv(input logic [WIDTH-1:0] d);
      return (d < WIDTH'(DIV_MIN)) ? WIDTH'(DIV_MIN) : d;
   endfunction

   // ceil(d/2) without widening: the carry-in of the odd bit cannot overflow
   function automatic logic [WIDTH-1:0] halfUp(input logic [WIDTH-1:0] d);
      return (d >> 1) + {{(WIDTH-1){1'b0}}, d[0]};
   endfunction

   chanState_t       state, stateNxt;
   logic [WIDTH-1:0] cnt, cntNxt;
   logic [WIDTH-1:0] divAct, divNxt;
   logic [WIDTH-1:0] pend, pendNxt;
   logic             pendVld, pendVldNxt;
   logic             wrap;
   logic             clkOutNxt, tickNxt;

   assign wrap     = (cnt == divAct - WIDTH'(1));
   assign pendFull = pendVld;

   always_comb begin
      stateNxt   = state;
      cntNxt     = cnt;
      divNxt     = divAct;
      pendNxt    = pend;
      pendVldNxt = pendVld;
      if (state == STOPPED) begin
         // no period in flight, so a new divisor can be taken immediately
         cntNxt = '0;
         if (ldValid) divNxt = clampDiv(ldData);
         if (en) stateNxt = RUNNING;
      end else begin
         if (ldValid) begin
            pendNxt    = clampDiv(ldData);
            pendVldNxt = 1'b1;
         end
         if (wrap || syncReq) begin
            cntNxt = '0;
            if (pendVld) begin
               divNxt     = pend;
               pendVldNxt = 1'b0;
            end
            if (!en && wrap && !syncReq) stateNxt = STOPPED;
            else stateNxt = en ? RUNNING : STOPPING;
         end else begin
            cntNxt   = cnt + WIDTH'(1);
            stateNxt = en ? RUNNING : STOPPING;
         end
      end
      clkOutNxt = (stateNxt != STOPPED) && (cntNxt < halfUp(divNxt));
      tickNxt   = (stateNxt != STOPPED) && (cntNxt == '0);
   end

   always_ff @(posedge clkIn or negedge rstN) begin
      if (!rstN) begin
         state   <= STOPPED;
         cnt     <= '0;
         divAct  <= RST_DIV;
         pend    <= '0;
         pendVld <= 1'b0;
         clkOut  <= 1'b0;
         tick    <= 1'b0;
      end else begin
         state   <= stateNxt;
         cnt     <= cntNxt;
         divAct  <= divNxt;
         pend    <= pendNxt;
         pendVld <= pendVldNxt;
         clkOut  <= clkOutNxt;
         tick    <= tickNxt;
      end
   end

endmodule

// File: rtl/clkdiv_bank.sv
// Bank of NCH independent clock dividers sharing one divisor-load port.
// Optional feature: define CLKDIV_SYNC_EN to add syncStart (phase-align all running channels).
module clkdiv_bank
   import clkdiv_pkg::*;
#(
   parameter int  NCH         = 4,
   parameter int  WIDTH       = 16,
   parameter int  DEFAULT_DIV = 2,
   localparam int SELW        = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clkIn,
   input  logic             rstN,
`ifdef CLKDIV_SYNC_EN
   input  logic             syncStart,
`endif
   input  logic [NCH-1:0]   en,
   input  logic [SELW-1:0]  divSel,
   input  logic [WIDTH-1:0] divData,
   input  logic             divValid,
   output logic             divReady,
   output logic [NCH-1:0]   clkOut,
   output logic [NCH-1:0]   tick
);

   logic [NCH-1:0] pendFull;
   logic [NCH-1:0] ldValid;
   logic           syncReq;

`ifdef CLKDIV_SYNC_EN
   assign syncReq = syncStart;
`else
   assign syncReq = 1'b0;
`endif

   // out-of-range selects never report ready, so such loads are dropped
   always_comb begin
      divReady = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (divSel == SELW'(i)) divReady = !pendFull[i];
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : gChan
      assign ldValid[g] = divValid && divReady && (divSel == SELW'(g));

      clkdiv_chan #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) uChan (
         .clkIn    (clkIn),
         .rstN     (rstN),
         .en       (en[g]),
         .syncReq  (syncReq),
         .ldValid  (ldValid[g]),
         .ldData   (divData),
         .pendFull (pendFull[g]),
         .clkOut   (clkOut[g]),
         .tick     (tick[g])
      );
   end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Self-checking bench for clkdiv_bank: per-channel period scoreboard plus directed checks.
// Exercises the syncStart path only when CLKDIV_SYNC_EN is defined.
module tb_clkdiv_bank;

   localparam int NCH   = 4;
   localparam int WIDTH = 16;

   typedef struct {
      int hi;
      int lo;
   } periodT;

   logic             clkIn = 1'b0;
   logic             rstN;
   logic [NCH-1:0]   en;
   logic [1:0]       divSel;
   logic [WIDTH-1:0] divData;
   logic             divValid;
   logic             divReady;
   logic [NCH-1:0]   clkOut;
   logic [NCH-1:0]   tick;
`ifdef CLKDIV_SYNC_EN
   logic             syncStart;
`endif

   int             errCnt = 0;
   int             chkCnt = 0;
   periodT         sb[NCH][$];
   logic [NCH-1:0] mon = '0;
   bit             started[NCH];
   bit             prevTick[NCH];
   int             hiCnt[NCH];
   int             loCnt[NCH];
   int             activity;

   clkdiv_bank #(
      .NCH         (NCH),
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (2)
   ) dut (
      .clkIn     (clkIn),
      .rstN      (rstN),
`ifdef CLKDIV_SYNC_EN
      .syncStart (syncStart),
`endif
      .en        (en),
      .divSel    (divSel),
      .divData   (divData),
      .divValid  (divValid),
      .divReady  (divReady),
      .clkOut    (clkOut),
      .tick      (tick)
   );

   always #5 clkIn = ~clkIn;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clkIn);
         #1;
      end
   endtask

   task automatic pushPeriods(input int c, input int d, input int n);
      periodT p;
      p.hi = (d + 1) / 2;
      p.lo = d / 2;
      repeat (n) sb[c].push_back(p);
   endtask

   task automatic loadDiv(input int sel, input logic [WIDTH-1:0] val);
      divSel   = 2'(sel);
      divData  = val;
      divValid = 1'b1;
      #1;
      checkVal($sformatf("loadRdy%0d", sel), divReady, 1);
      step(1);
      divValid = 1'b0;
   endtask

   task automatic waitTick(input int c, input int bound);
      bit got = 1'b0;
      int n = 0;
      while (!got && n < bound) begin
         step(1);
         n++;
         if (tick[c]) got = 1'b1;
      end
      if (!got) checkVal($sformatf("tickTimeout%0d", c), got, 1);
   endtask

   task automatic waitSbEmpty(input int c, input int bound);
      bit got = 1'b0;
      int n = 0;
      while (!got && n < bound) begin
         if (sb[c].size() == 0) got = 1'b1;
         else begin
            step(1);
            n++;
         end
      end
      if (!got) checkVal($sformatf("sbTimeout%0d", c), sb[c].size(), 0);
      mon[c] = 1'b0;
   endtask

   // Measures every clkOut period between consecutive ticks and pops the expectation.
   always @(negedge clkIn) begin : monitor
      periodT e;
      for (int c = 0; c < NCH; c++) begin
         if (!mon[c]) begin
            started[c]  = 1'b0;
            prevTick[c] = 1'b0;
         end else begin
            if (prevTick[c]) checkVal($sformatf("tickWidth%0d", c), tick[c], 0);
            if (tick[c]) begin
               checkVal($sformatf("tickHigh%0d", c), clkOut[c], 1);
               if (started[c]) begin
                  checkVal($sformatf("sbNonEmpty%0d", c), sb[c].size() > 0, 1);
                  if (sb[c].size() > 0) begin
                     e = sb[c].pop_front();
                     checkVal($sformatf("periodHigh%0d", c), hiCnt[c], e.hi);
                     checkVal($sformatf("periodLow%0d", c), loCnt[c], e.lo);
                  end
               end
               started[c] = 1'b1;
               hiCnt[c]   = 0;
               loCnt[c]   = 0;
            end
            if (started[c]) begin
               if (clkOut[c]) hiCnt[c]++;
               else loCnt[c]++;
            end
            prevTick[c] = tick[c];
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstN     = 1'b0;
      en       = '0;
      divSel   = '0;
      divData  = '0;
      divValid = 1'b0;
`ifdef CLKDIV_SYNC_EN
      syncStart = 1'b0;
`endif
      step(3);

      // Reset state
      checkVal("rstClkOut", clkOut, 0);
      checkVal("rstTick", tick, 0);
      for (int s = 0; s < NCH; s++) begin
         divSel = 2'(s);
         #1;
         checkVal($sformatf("rstRdy%0d", s), divReady, 1);
      end
      rstN = 1'b1;
      step(2);
      checkVal("idleClkOut", clkOut, 0);

      // Default divisor 2 on channel 0
      en[0]  = 1'b1;
      mon[0] = 1'b1;
      pushPeriods(0, 2, 10);
      step(1);
      checkVal("startClk0", clkOut[0], 1);
      checkVal("startTick0", tick[0], 1);
      waitSbEmpty(0, 100);

      // Divisor 5 loaded while stopped on channel 1
      loadDiv(1, 16'd5);
      en[1]  = 1'b1;
      mon[1] = 1'b1;
      pushPeriods(1, 5, 10);
      waitSbEmpty(1, 200);

      // Channel 2: 4 -> 7 mid-period, then a load on the wrap cycle
      loadDiv(2, 16'd4);
      en[2]  = 1'b1;
      mon[2] = 1'b1;
      pushPeriods(2, 4, 1);
      pushPeriods(2, 7, 3);
      pushPeriods(2, 3, 2);
      waitTick(2, 10);
      step(1);
      loadDiv(2, 16'd7);
      checkVal("pendRdyCnt2", divReady, 0);
      step(1);
      checkVal("pendRdyCnt3", divReady, 0);
      step(1);
      checkVal("wrapTick2", tick[2], 1);
      checkVal("wrapRdy2", divReady, 1);
      waitTick(2, 20);
      step(6);
      loadDiv(2, 16'd3);
      waitSbEmpty(2, 100);

      // Channel 3, divisor 6: cancelled stop, then a real stop
      loadDiv(3, 16'd6);
      en[3]  = 1'b1;
      mon[3] = 1'b1;
      pushPeriods(3, 6, 3);
      waitTick(3, 10);
      step(2);
      en[3] = 1'b0;
      step(2);
      en[3] = 1'b1;
      waitTick(3, 20);
      waitTick(3, 20);
      waitTick(3, 20);
      step(2);
      checkVal("sbDrain3", sb[3].size(), 0);
      mon[3] = 1'b0;
      checkVal("stopCnt2", clkOut[3], 1);
      en[3] = 1'b0;
      step(1);
      checkVal("stopCnt3", clkOut[3], 0);
      step(1);
      checkVal("stopCnt4", clkOut[3], 0);
      step(1);
      checkVal("stopCnt5", clkOut[3], 0);
      activity = 0;
      for (int n = 0; n < 20; n++) begin
         step(1);
         if (clkOut[3] || tick[3]) activity++;
      end
      checkVal("stoppedQuiet3", activity, 0);

      // Divisor 0 clamps to 2, then the widest divisor
      loadDiv(3, 16'd0);
      en[3]  = 1'b1;
      mon[3] = 1'b1;
      pushPeriods(3, 2, 4);
      waitSbEmpty(3, 50);
      en[3] = 1'b0;
      step(8);
      loadDiv(3, 16'hFFFF);
      en[3]  = 1'b1;
      mon[3] = 1'b1;
      pushPeriods(3, 65535, 1);
      waitSbEmpty(3, 70000);

      // Asynchronous reset mid-period, with a pending divisor outstanding
      loadDiv(3, 16'd100);
      divSel = 2'd3;
      #1;
      checkVal("preRstRdy3", divReady, 0);
      checkVal("preRstClk3", clkOut[3], 1);
      #2;
      rstN = 1'b0;
      #1;
      checkVal("asyncRstClk", clkOut, 0);
      checkVal("asyncRstTick", tick, 0);
      for (int s = 0; s < NCH; s++) begin
         divSel = 2'(s);
         #1;
         checkVal($sformatf("inRstRdy%0d", s), divReady, 1);
      end
      step(1);
      checkVal("holdRstClk", clkOut, 0);
      rstN   = 1'b1;
      mon[1] = 1'b1;
      mon[3] = 1'b1;
      pushPeriods(1, 2, 3);
      pushPeriods(3, 2, 3);
      step(1);
      checkVal("relClkOut", clkOut, 4'hF);
      checkVal("relTick", tick, 4'hF);
      waitSbEmpty(1, 30);
      waitSbEmpty(3, 30);

`ifdef CLKDIV_SYNC_EN
      // Phase alignment of D=3 and D=5 channels
      loadDiv(1, 16'd3);
      loadDiv(2, 16'd5);
      step(12);
      waitTick(1, 10);
      step(1);
      syncStart = 1'b1;
      step(1);
      syncStart = 1'b0;
      checkVal("syncTick1", tick[1], 1);
      checkVal("syncTick2", tick[2], 1);
      checkVal("syncClk1", clkOut[1], 1);
      checkVal("syncClk2", clkOut[2], 1);
      step(3);
      checkVal("syncNext1", tick[1], 1);
      checkVal("syncMid2", tick[2], 0);
      step(2);
      checkVal("syncNext2", tick[2], 1);
`endif

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule

// File: doc/clkdiv_bank.md
CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
- REQ-001 SHALL have parameter NCH, default 4: number of independent divider channels (1..16).
- REQ-002 SHALL have parameter WIDTH, default 16: divisor width in bits.
- REQ-003 SHALL have parameter DEFAULT_DIV, default 2: divisor loaded into every channel at reset.
- REQ-004 SHALL have port clkIn, input, 1: the single clock; all logic on its rising edge.
- REQ-005 SHALL have port rstN, input, 1: asynchronous, active-low reset.
- REQ-006 SHALL have port en, input, NCH: per-channel run enable.
- REQ-007 SHALL have port divSel, input, max(1,$clog2(NCH)): channel addressed by a divisor load.
- REQ-008 SHALL have port divData, input, WIDTH: new divisor value.
- REQ-009 SHALL have port divValid, input, 1: divisor load request.
- REQ-010 SHALL have port divReady, output, 1: the addressed channel can accept a load.
- REQ-011 SHALL have port clkOut, output, NCH: divided clocks, registered.
- REQ-012 SHALL have port tick, output, NCH: one-cycle pulse on each clkOut rising edge.
- REQ-013 SHALL have port syncStart, input, 1, present only with CLKDIV_SYNC_EN.

Function
- REQ-014 Each channel SHALL hold an active divisor D; loaded values 0 and 1 SHALL be clamped to 2.
- REQ-015 A running channel SHALL keep counter cnt, which counts 0..D-1 and wraps to 0.
- REQ-016 clkOut SHALL be 1 while cnt < ceil(D/2), else 0: period exactly D clkIn cycles, high ceil(D/2), low floor(D/2).
- REQ-017 tick[i] SHALL be 1 for exactly the cycle in which cnt==0 and the channel is running.
- REQ-018 A load SHALL be accepted on a cycle with divValid && divReady; divReady SHALL be !pending[divSel] (combinational).
- REQ-019 An accepted value SHALL go into the channel's pending register; a running channel SHALL copy it to D at the wrap (cnt D-1 -> 0) and clear pending, so no runt or stretched pulse occurs.
- REQ-020 A stopped channel SHALL adopt the pending value on the cycle after acceptance.
- REQ-021 Start: with en[i] rising while stopped, the next edge SHALL set cnt=0, clkOut=1, tick=1.
- REQ-022 Stop: with en[i] low while running, the channel SHALL finish the current period, stop at the wrap, and then hold clkOut=0, cnt=0.
- REQ-023 Re-asserting en[i] before that wrap SHALL cancel the stop with no disturbance.
- REQ-024 A load and a wrap in the same cycle on the same channel SHALL take effect at the following wrap.
- REQ-025 D=2 SHALL give clkIn/2 with 50% duty; D=2^WIDTH-1 SHALL be supported without overflow.

Reset
- REQ-026 rstN low SHALL asynchronously set clkOut=0, tick=0, cnt=0, pending=0, D=DEFAULT_DIV and the stopped state on all channels, including mid-period.
- REQ-027 divReady SHALL read 1 during and after reset.
- REQ-028 Reset release SHALL be used synchronously: the first start is on the first rising edge after release with en high.

Configuration
- REQ-029 Macro CLKDIV_SYNC_EN SHALL control the syncStart feature.
- REQ-030 With CLKDIV_SYNC_EN defined: syncStart high SHALL force every running channel to cnt=0, clkOut=1, tick=1 on the next edge and apply any pending divisor. This aligns phases; a truncated period is permitted.
- REQ-031 Without CLKDIV_SYNC_EN: the syncStart port SHALL be absent and behaviour SHALL be exactly as in REQ-014..REQ-025.

Structure
- REQ-032 Package clkdiv_pkg SHALL hold DIV_MIN=2 and the channel state enum (STOPPED, RUNNING, STOPPING).
- REQ-033 Per-channel logic SHALL be sub-module clkdiv_chan, instantiated NCH times by generate; load decode and divReady mux SHALL be in clkdiv_bank.

Verification
- REQ-034 Bench SHALL cover: reset, DEFAULT_DIV=2, en[0]=1 -> clkOut[0] toggles every cycle, tick[0] every 2nd cycle.
- REQ-035 Bench SHALL cover: load D=5 on ch1 while stopped, en[1]=1 -> period 5, high 3, low 2, repeated 10 periods.
- REQ-036 Bench SHALL cover: ch2 running D=4, load D=7 at cnt=1 -> current period still 4 cycles, then 7; divReady low for divSel=2 until that wrap.
- REQ-037 Bench SHALL cover: en[3] dropped at cnt=2 of D=6 -> clkOut completes the period, then stays 0; en re-raised at cnt=4 -> no gap.
- REQ-038 Bench SHALL cover: load divData=0 -> behaves as D=2; load 16'hFFFF -> period 65535.
- REQ-039 Bench SHALL cover: rstN pulsed low mid-period -> all outputs 0 immediately; with CLKDIV_SYNC_EN, syncStart on channels with D=3 and D=5 -> coincident ticks next cycle.
